cfg_chain_loader: RTL and testbench

Bitstream loader that drives the fabric's configuration shift chain. It accepts configuration words from the host over a valid/ready stream, serializes them LSB-first onto the chain input, and generates the chain's shift clock. It holds the fabric flops in reset for the whole load and releases them only once the chain is fully loaded. Optionally, it captures the bits leaving the chain end as a readback stream. It sits between the host interface and the first `shift_i` of the cell array.

---
 rtl/cfg_pkg.sv | 20 ++
 rtl/cfg_clk_div.sv | 41 ++++
 rtl/cfg_chain_loader.sv | 145 ++++++++++++++
 tb/tb_cfg_chain_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and defaults for the configuration chain loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_FETCH,
    CFG_SHIFT,
    CFG_DONE
  } cfg_state_t;

  localparam int CFG_CHAIN_LEN = 256;
  localparam int CFG_WORD_W    = 8;
  localparam int CFG_DIV       = 2;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_clk_div.sv
// Shift-clock generator: DIV clk cycles per half-period, frozen while en is low.
module cfg_clk_div
  import cfg_pkg::*;
#(
  parameter int DIV = CFG_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic chain_clk,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(DIV);

  logic [CW-1:0] cnt;
  logic          half_end;

  // Strobes flag the cycle whose closing clk edge toggles chain_clk.
  assign half_end = en && (cnt == CW'(DIV - 1));
  assign rise     = half_end && !chain_clk;
  assign fall     = half_end && chain_clk;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      chain_clk <= 1'b0;
    end else if (en) begin
      if (half_end) begin
        cnt       <= '0;
        chain_clk <= ~chain_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial bitstream loader for the fabric configuration chain.
// Optional chain readback is built only when CFG_READBACK_EN is defined.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int WORD_W    = CFG_WORD_W,
  parameter int DIV       = CFG_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              chain_clk,
  output logic              chain_d,
  input  logic              chain_q,
  output logic              fabric_rst,
  output logic              busy,
  output logic              done,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int IW  = cnt_w(WORD_W);

  cfg_state_t        state, state_nxt;
  logic [BCW-1:0]    bit_cnt;
  logic [IW-1:0]     bit_idx;
  logic [WORD_W-1:0] sreg, sreg_shr;
  logic              div_en, rise, fall;
  logic              last_bit, word_end, load_done;
  logic              rb_idle, rb_stall;

  assign sreg_shr = sreg >> 1;
  assign last_bit = (bit_cnt == BCW'(CHAIN_LEN));
  assign word_end = (bit_idx == IW'(WORD_W - 1));
  assign in_ready = (state == CFG_FETCH);

  // Finishing waits for the last fall and for any pending readback word.
  assign load_done = (state == CFG_SHIFT) && last_bit && (fall || !chain_clk) && rb_idle;
  // Only the low phase is frozen, so a stall always parks chain_clk low.
  assign div_en    = (state == CFG_SHIFT) && !(!chain_clk && (last_bit || rb_stall));

  cfg_clk_div #(.DIV(DIV)) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (div_en),
    .chain_clk (chain_clk),
    .rise      (rise),
    .fall      (fall)
  );

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CFG_IDLE, CFG_DONE: if (start) state_nxt = CFG_FETCH;
      CFG_FETCH:          if (in_valid) state_nxt = CFG_SHIFT;
      CFG_SHIFT: begin
        if (load_done)                         state_nxt = CFG_DONE;
        else if (fall && !last_bit && word_end) state_nxt = CFG_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CFG_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      sreg       <= '0;
      chain_d    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fabric_rst <= 1'b1;
    end else begin
      state <= state_nxt;
      // Status is registered from the next state so fabric_rst cannot glitch.
      busy       <= (state_nxt == CFG_FETCH) || (state_nxt == CFG_SHIFT);
      done       <= (state_nxt == CFG_DONE);
      fabric_rst <= (state_nxt != CFG_DONE);

      if ((state == CFG_IDLE || state == CFG_DONE) && start) bit_cnt <= '0;
      if (rise) bit_cnt <= bit_cnt + 1'b1;

      if (state == CFG_FETCH && in_valid) begin
        sreg    <= in_data;
        chain_d <= in_data[0];
        bit_idx <= '0;
      end else if (fall && !last_bit && !word_end) begin
        sreg    <= sreg_shr;
        chain_d <= sreg_shr[0];
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [IW-1:0]     rb_cnt;
  logic [WORD_W-1:0] rb_sh, rb_next;
  logic              rb_final;

  // New bits enter at the top, so after WORD_W bits the first one sits in the LSB.
  assign rb_next  = (rb_sh >> 1) | (WORD_W'(chain_q) << (WORD_W - 1));
  assign rb_final = (bit_cnt == BCW'(CHAIN_LEN - 1));
  assign rb_idle  = !rb_valid || rb_ready;
  assign rb_stall = rb_valid && !rb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
      rb_cnt   <= '0;
      rb_sh    <= '0;
    end else begin
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      if (rise) begin
        if (rb_cnt == IW'(WORD_W - 1) || rb_final) begin
          // A short final word is right-aligned and zero-padded.
          rb_valid <= 1'b1;
          rb_data  <= rb_next >> (IW'(WORD_W - 1) - rb_cnt);
          rb_cnt   <= '0;
          rb_sh    <= '0;
        end else begin
          rb_sh  <= rb_next;
          rb_cnt <= rb_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_rb_inputs;

  assign rb_valid         = 1'b0;
  assign rb_data          = '0;
  assign rb_idle          = 1'b1;
  assign rb_stall         = 1'b0;
  assign unused_rb_inputs = chain_q ^ rb_ready;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench: two loaders (16-bit and 12-bit chains) against a chain model.
module tb_cfg_chain_loader;

  localparam int DIV = 2;

  typedef struct {
    int          unit;
    logic [15:0] chain;
    int          lat;
    int          edges;
  } exp_t;

  typedef struct {
    int         unit;
    logic [7:0] data;
  } rb_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      start = '0, in_valid = '0, rb_ready = 2'b11;
  logic [1:0][7:0] in_data = '0;
  logic [1:0]      in_ready, chain_clk, chain_d, chain_q, fabric_rst, busy, done, rb_valid;
  logic [1:0][7:0] rb_data;

  logic [15:0] chain0 = '0, chain1 = '0;
  int          edges0 = 0, edges1 = 0;
  int          cyc = 0;
  int          n_vec = 0, n_bad = 0;
  exp_t        sb[$];
  rb_t         rb_q[$];
  bit          rb_quiet = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cfg_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .DIV(DIV)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .chain_clk(chain_clk[0]),
    .chain_d(chain_d[0]), .chain_q(chain_q[0]), .fabric_rst(fabric_rst[0]),
    .busy(busy[0]), .done(done[0]), .rb_valid(rb_valid[0]),
    .rb_ready(rb_ready[0]), .rb_data(rb_data[0])
  );

  cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .DIV(DIV)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .chain_clk(chain_clk[1]),
    .chain_d(chain_d[1]), .chain_q(chain_q[1]), .fabric_rst(fabric_rst[1]),
    .busy(busy[1]), .done(done[1]), .rb_valid(rb_valid[1]),
    .rb_ready(rb_ready[1]), .rb_data(rb_data[1])
  );

  // Chain model: first-shifted bit travels to bit 0, the chain end.
  always @(posedge chain_clk[0]) begin
    chain0 <= {chain_d[0], chain0[15:1]};
    edges0++;
  end
  always @(posedge chain_clk[1]) begin
    chain1 <= {4'h0, chain_d[1], chain1[11:1]};
    edges1++;
  end
  assign chain_q = {chain1[0], chain0[0]};

  function automatic int len_of(input int u);
    return (u == 0) ? 16 : 12;
  endfunction
  function automatic logic [15:0] chain_of(input int u);
    return (u == 0) ? chain0 : chain1;
  endfunction
  function automatic int edges_of(input int u);
    return (u == 0) ? edges0 : edges1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef CFG_READBACK_EN
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rb_valid[u] && rb_ready[u]) begin
        check("rb_expected_pending", 32'(rb_q.size() > 0), 1);
        if (rb_q.size() > 0) begin
          rb_t r = rb_q.pop_front();
          check("rb_unit", u, r.unit);
          check("rb_data", rb_data[u], r.data);
        end
      end
    end
  end
`else
  always @(negedge clk) if (rb_valid != '0 || rb_data != '0) rb_quiet = 1'b0;
`endif

  task automatic wait_hs(input int u);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (in_ready[u] && in_valid[u]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("handshake", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input int u);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready[u]) begin
        ok = 1'b1;
        break;
      end
    end
    check("fetch_reached", ok, 1);
  endtask

  // Two-word load; gap = cycles in_valid is withheld once the loader sits in FETCH.
  task automatic load(input int u, input logic [7:0] w0, input logic [7:0] w1,
                      input int gap, input bit mid_start, input int extra);
    exp_t        e;
    int          t0, e0;
    bit          clk_low = 1'b1, seen = 1'b0;
    logic        prev_fr = 1'b1;
    logic [15:0] pre = chain_of(u);
    e.unit  = u;
    e.chain = (u == 0) ? {w1, w0} : ({w1, w0} & 16'h0FFF);
    e.lat   = len_of(u) * 2 * DIV + 2 + 1 + gap + extra;
    e.edges = len_of(u);
    sb.push_back(e);
`ifdef CFG_READBACK_EN
    rb_q.push_back('{u, pre[7:0]});
    rb_q.push_back('{u, pre[15:8]});
`endif
    e0 = edges_of(u);
    @(posedge clk);
    #1;
    start[u] = 1'b1; in_valid[u] = 1'b1; in_data[u] = w0;
    t0 = cyc;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    check("busy_after_start", busy[u], 1);
    wait_hs(u);
    in_valid[u] = 1'b0;
    if (mid_start) begin
      start[u] = 1'b1;
      @(posedge clk);
      #1;
      start[u] = 1'b0;
    end
    wait_fetch(u);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (chain_clk[u]) clk_low = 1'b0;
    end
    if (gap > 0) check("starve_clk_low", clk_low, 1);
    in_valid[u] = 1'b1; in_data[u] = w1;
    wait_hs(u);
    in_valid[u] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done[u]) begin
        seen = 1'b1;
        break;
      end
      prev_fr = fabric_rst[u];
    end
    check("done_seen", seen, 1);
    e = sb.pop_front();
    check("chain", chain_of(e.unit), e.chain);
    check("latency", cyc - t0, e.lat);
    check("edges", edges_of(u) - e0, e.edges);
    check("fabric_rst_before_done", prev_fr, 1);
    check("fabric_rst_at_done", fabric_rst[u], 0);
    check("busy_at_done", busy[u], 0);
  endtask

  initial begin
    int e0;
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_outs", {in_ready[u], chain_clk[u], chain_d[u], fabric_rst[u],
                           busy[u], done[u], rb_valid[u]}, 7'b0001000);
      check("reset_rb_data", rb_data[u], 0);
    end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", {in_ready[0], fabric_rst[0], busy[0], done[0]}, 4'b0100);

    load(0, 8'hA5, 8'h3C, 0, 1'b0, 0);   // basic load
    load(0, 8'hA5, 8'h3C, 10, 1'b0, 0);  // starved between words
    load(1, 8'hFF, 8'h0A, 0, 1'b0, 0);   // partial final word
    load(0, 8'h5A, 8'hC3, 0, 1'b1, 0);   // start pulsed mid-load

    // Abort by reset after five rising edges.
    e0 = edges0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    start[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h96;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (edges0 - e0 >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_edges_reached", ok, 1);
    rst_n = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_outs", {chain_clk[0], fabric_rst[0], busy[0], done[0]}, 4'b0100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load(0, 8'h0F, 8'hF0, 0, 1'b0, 0);   // reload after abort

`ifdef CFG_READBACK_EN
    load(0, 8'h34, 8'h12, 0, 1'b0, 0);   // preload 0x1234
    rb_ready[0] = 1'b0;
    fork
      load(0, 8'h00, 8'h00, 0, 1'b0, 8);
      begin
        bit hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
          @(negedge clk);
          if (rb_valid[0] && !chain_clk[0] && busy[0] && !in_ready[0]) begin
            hit = 1'b1;
            break;
          end
        end
        check("rb_stall_reached", hit, 1);
        repeat (8) @(posedge clk);
        #1 rb_ready[0] = 1'b1;
      end
    join
    check("rb_words_left", rb_q.size(), 0);
`else
    check("rb_outputs_quiet", rb_quiet, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
